// File: rtl/fs_accel_wbank_if.sv
// rtl/fs_accel_wbank_if.sv - load/swap/control bus between the weight bank and its user
interface fs_accel_wbank_if #(
  parameter int DW   = 8,
  parameter int TAPS = 3,
  parameter int ROWS = 3
);
  localparam int N  = TAPS * ROWS;
  localparam int CW = $clog2(N + 1);

  logic          enb;
  logic          clr;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          swap;
  logic          swap_err;
  logic [CW-1:0] fill_cnt;
  logic          shadow_full;
  logic          act_valid;
  logic [N*DW-1:0] wreg_do;

  modport master (
    output enb, clr, ld_valid, ld_data, swap,
    input  ld_ready, swap_err, fill_cnt, shadow_full, act_valid, wreg_do
  );

  modport slave (
    input  enb, clr, ld_valid, ld_data, swap,
    output ld_ready, swap_err, fill_cnt, shadow_full, act_valid, wreg_do
  );
endinterface

// File: rtl/fs_accel_wbank.sv
// rtl/fs_accel_wbank.sv - double-buffered kernel weight bank (shadow load, active swap)
module fs_accel_wbank #(
  parameter int DW   = 8,
  parameter int TAPS = 3,
  parameter int ROWS = 3
) (
  input  logic           clk,
  input  logic           resetn,
  fs_accel_wbank_if.slave bus
);
  localparam int N  = TAPS * ROWS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {S_LOAD = 1'b0, S_FULL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N*DW-1:0] r_shadow;
  logic [N*DW-1:0] r_active;
  logic [CW-1:0]   r_fill;
  logic            r_act_valid;
  logic            r_swap_err;
  logic            w_ld_ready;
  logic            w_accept;
  logic            w_last;
  logic            w_swap_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_LOAD;
    else         r_state <= w_state_nxt;
  end

  // A swap only commits from FULL; a swap on the final-load edge is still seen in LOAD.
  always_comb begin
    w_ld_ready  = 1'b0;
    w_state_nxt = r_state;
    if (r_state == S_LOAD) w_ld_ready = bus.enb & ~bus.clr;
    w_accept  = bus.ld_valid & w_ld_ready;
    w_last    = w_accept && (r_fill == CW'(N - 1));
    w_swap_ok = bus.enb & ~bus.clr & bus.swap & (r_state == S_FULL);
    if (bus.enb) begin
      if (bus.clr)        w_state_nxt = S_LOAD;
      else if (w_last)    w_state_nxt = S_FULL;
      else if (w_swap_ok) w_state_nxt = S_LOAD;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shadow    <= '0;
      r_active    <= '0;
      r_fill      <= '0;
      r_act_valid <= 1'b0;
      r_swap_err  <= 1'b0;
    end else if (bus.enb) begin
      if (bus.clr) begin
        r_shadow    <= '0;
        r_active    <= '0;
        r_fill      <= '0;
        r_act_valid <= 1'b0;
        r_swap_err  <= 1'b0;
      end else begin
        r_swap_err <= bus.swap & (r_state == S_LOAD);
        if (w_accept) begin
          r_shadow[r_fill*DW +: DW] <= bus.ld_data;
          r_fill                    <= r_fill + CW'(1);
        end
        // Shadow is left intact on swap; later loads simply overwrite it.
        if (w_swap_ok) begin
          r_active    <= r_shadow;
          r_act_valid <= 1'b1;
          r_fill      <= '0;
        end
      end
    end else begin
      r_swap_err <= 1'b0;
    end
  end

  assign bus.ld_ready    = w_ld_ready;
  assign bus.swap_err    = r_swap_err;
  assign bus.fill_cnt    = r_fill;
  assign bus.shadow_full = (r_state == S_FULL);
  assign bus.act_valid   = r_act_valid;
  assign bus.wreg_do     = r_active;
endmodule

// File: tb/tb_fs_accel_wbank.sv
// tb/tb_fs_accel_wbank.sv - directed self-checking bench for fs_accel_wbank
module tb_fs_accel_wbank;
  logic clk;
  logic resetn;
  int   n_checks;
  int   n_pass;

  fs_accel_wbank_if #(.DW(8), .TAPS(3), .ROWS(3)) bus ();

  fs_accel_wbank #(.DW(8), .TAPS(3), .ROWS(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic do_swap();
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.enb = 1'b1; bus.clr = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.swap = 1'b0;
    tick(); tick();
    n_checks++; if (bus.wreg_do !== 72'h0) $display("FAIL reset_wreg act=%h exp=0", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.fill_cnt !== 4'd0) $display("FAIL reset_fill act=%0d exp=0", bus.fill_cnt); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b0) $display("FAIL reset_act_valid act=%b exp=0", bus.act_valid); else n_pass++;
    n_checks++; if (bus.shadow_full !== 1'b0) $display("FAIL reset_full act=%b exp=0", bus.shadow_full); else n_pass++;
    n_checks++; if (bus.swap_err !== 1'b0) $display("FAIL reset_swap_err act=%b exp=0", bus.swap_err); else n_pass++;
    n_checks++; if (bus.ld_ready !== 1'b1) $display("FAIL reset_ld_ready act=%b exp=1", bus.ld_ready); else n_pass++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_full_load_swap();
    for (int i = 0; i < 9; i++) begin
      load(8'(i + 1));
      n_checks++; if (bus.fill_cnt !== 4'(i + 1)) $display("FAIL stream_fill%0d act=%0d exp=%0d", i, bus.fill_cnt, i + 1); else n_pass++;
    end
    n_checks++; if (bus.shadow_full !== 1'b1) $display("FAIL stream_full act=%b exp=1", bus.shadow_full); else n_pass++;
    n_checks++; if (bus.ld_ready !== 1'b0) $display("FAIL stream_ready_full act=%b exp=0", bus.ld_ready); else n_pass++;
    do_swap();
    n_checks++; if (bus.wreg_do !== 72'h090807060504030201) $display("FAIL swap_wreg act=%h exp=090807060504030201", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b1) $display("FAIL swap_act_valid act=%b exp=1", bus.act_valid); else n_pass++;
    n_checks++; if (bus.fill_cnt !== 4'd0) $display("FAIL swap_fill act=%0d exp=0", bus.fill_cnt); else n_pass++;
    n_checks++; if (bus.shadow_full !== 1'b0) $display("FAIL swap_full act=%b exp=0", bus.shadow_full); else n_pass++;
  endtask

  task automatic test_swap_err();
    for (int i = 0; i < 5; i++) load(8'(8'h11 + i));
    do_swap();
    n_checks++; if (bus.swap_err !== 1'b1) $display("FAIL swap_err_pulse act=%b exp=1", bus.swap_err); else n_pass++;
    n_checks++; if (bus.fill_cnt !== 4'd5) $display("FAIL swap_err_fill act=%0d exp=5", bus.fill_cnt); else n_pass++;
    n_checks++; if (bus.wreg_do !== 72'h090807060504030201) $display("FAIL swap_err_wreg act=%h exp=090807060504030201", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b1) $display("FAIL swap_err_act_valid act=%b exp=1", bus.act_valid); else n_pass++;
    tick();
    n_checks++; if (bus.swap_err !== 1'b0) $display("FAIL swap_err_drop act=%b exp=0", bus.swap_err); else n_pass++;
  endtask

  task automatic test_hold_full();
    for (int i = 5; i < 9; i++) load(8'(8'h11 + i));
    bus.ld_valid = 1'b1; bus.ld_data = 8'hAA;
    tick(); tick(); tick();
    n_checks++; if (bus.fill_cnt !== 4'd9) $display("FAIL hold_fill act=%0d exp=9", bus.fill_cnt); else n_pass++;
    n_checks++; if (bus.ld_ready !== 1'b0) $display("FAIL hold_ready act=%b exp=0", bus.ld_ready); else n_pass++;
    bus.swap = 1'b1;
    tick();
    bus.swap = 1'b0;
    bus.ld_data = 8'hBB;
    n_checks++; if (bus.wreg_do !== 72'h191817161514131211) $display("FAIL hold_wreg act=%h exp=191817161514131211", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.fill_cnt !== 4'd0) $display("FAIL hold_swap_fill act=%0d exp=0", bus.fill_cnt); else n_pass++;
    tick();
    bus.ld_valid = 1'b0;
    n_checks++; if (bus.fill_cnt !== 4'd1) $display("FAIL hold_first_accept act=%0d exp=1", bus.fill_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) load(8'(8'hC1 + i));
    do_swap();
    n_checks++; if (bus.wreg_do !== 72'hC8C7C6C5C4C3C2C1BB) $display("FAIL hold_slot0 act=%h exp=c8c7c6c5c4c3c2c1bb", bus.wreg_do); else n_pass++;
  endtask

  task automatic test_clr_priority();
    for (int i = 0; i < 8; i++) load(8'(8'h21 + i));
    bus.ld_valid = 1'b1; bus.ld_data = 8'h29; bus.swap = 1'b1; bus.clr = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.swap = 1'b0; bus.clr = 1'b0;
    n_checks++; if (bus.wreg_do !== 72'h0) $display("FAIL clr_wreg act=%h exp=0", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.fill_cnt !== 4'd0) $display("FAIL clr_fill act=%0d exp=0", bus.fill_cnt); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b0) $display("FAIL clr_act_valid act=%b exp=0", bus.act_valid); else n_pass++;
    n_checks++; if (bus.swap_err !== 1'b0) $display("FAIL clr_swap_err act=%b exp=0", bus.swap_err); else n_pass++;
    n_checks++; if (bus.shadow_full !== 1'b0) $display("FAIL clr_full act=%b exp=0", bus.shadow_full); else n_pass++;
  endtask

  task automatic test_swap_on_last();
    for (int i = 0; i < 8; i++) load(8'(8'h31 + i));
    bus.ld_valid = 1'b1; bus.ld_data = 8'h39; bus.swap = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.swap = 1'b0;
    n_checks++; if (bus.swap_err !== 1'b1) $display("FAIL last_swap_err act=%b exp=1", bus.swap_err); else n_pass++;
    n_checks++; if (bus.shadow_full !== 1'b1) $display("FAIL last_full act=%b exp=1", bus.shadow_full); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b0) $display("FAIL last_act_valid act=%b exp=0", bus.act_valid); else n_pass++;
    do_swap();
    n_checks++; if (bus.wreg_do !== 72'h393837363534333231) $display("FAIL last_wreg act=%h exp=393837363534333231", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b1) $display("FAIL last_act_valid2 act=%b exp=1", bus.act_valid); else n_pass++;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) load(8'(8'h41 + i));
    do_swap();
    bus.enb = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 8'hEE; bus.swap = 1'b1; bus.clr = 1'b0;
    #1;
    n_checks++; if (bus.ld_ready !== 1'b0) $display("FAIL enb_ready act=%b exp=0", bus.ld_ready); else n_pass++;
    tick();
    n_checks++; if (bus.swap_err !== 1'b0) $display("FAIL enb_swap_err_drop act=%b exp=0", bus.swap_err); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (bus.fill_cnt !== 4'd3) $display("FAIL enb_fill act=%0d exp=3", bus.fill_cnt); else n_pass++;
    n_checks++; if (bus.wreg_do !== 72'h393837363534333231) $display("FAIL enb_wreg act=%h exp=393837363534333231", bus.wreg_do); else n_pass++;
    bus.enb = 1'b1; bus.ld_valid = 1'b0; bus.swap = 1'b0;
    for (int i = 3; i < 9; i++) load(8'(8'h41 + i));
    do_swap();
    n_checks++; if (bus.wreg_do !== 72'h494847464544434241) $display("FAIL enb_resume_wreg act=%h exp=494847464544434241", bus.wreg_do); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) load(8'(8'h51 + i));
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (bus.wreg_do !== 72'h0) $display("FAIL areset_wreg act=%h exp=0", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.fill_cnt !== 4'd0) $display("FAIL areset_fill act=%0d exp=0", bus.fill_cnt); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b0) $display("FAIL areset_act_valid act=%b exp=0", bus.act_valid); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) load(8'(8'h61 + i));
    do_swap();
    n_checks++; if (bus.wreg_do !== 72'h696867666564636261) $display("FAIL areset_reload_wreg act=%h exp=696867666564636261", bus.wreg_do); else n_pass++;
    n_checks++; if (bus.act_valid !== 1'b1) $display("FAIL areset_reload_valid act=%b exp=1", bus.act_valid); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_full_load_swap();
    test_swap_err();
    test_hold_full();
    test_clr_priority();
    test_swap_on_last();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
